// File: rtl/pixel_stream_buffer.sv
// Elastic pixel buffer between a frame-oriented upstream source and display timing.
// Aligns each frame's SOF word to the vertical sync falling edge, then drains one word per visible slot.
module pixel_stream_buffer #(
    parameter int HDISP = 800,
    parameter int VDISP = 480,
    parameter int DEPTH = 16
) (
    input  logic                       pixel_clk,
    input  logic                       pixel_rst,
    input  logic [23:0]                in_data,
    input  logic                       in_sof,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       vs,
    input  logic                       blank,
    output logic [23:0]                rgb_out,
    output logic                       underflow,
    output logic                       frame_err,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int AW    = $clog2(DEPTH);
    localparam int LW    = $clog2(DEPTH + 1);
    localparam int TOTAL = HDISP * VDISP;
    localparam int CW    = $clog2(TOTAL);

    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);
    localparam logic [CW-1:0] LAST_SLOT  = CW'(TOTAL - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARMED,
        STREAM
    } state_t;

    state_t         state_reg;
    logic [CW-1:0]  pix_cnt_reg;
    logic           vs_reg;
    logic [23:0]    rgb_reg;
    logic           underflow_reg;
    logic           frame_err_reg;

    // Entries are {sof, data}; head is read asynchronously so a pop delivers on the same edge.
    logic [24:0]    mem [DEPTH];
    logic [AW-1:0]  wr_ptr_reg;
    logic [AW-1:0]  rd_ptr_reg;
    logic [LW-1:0]  level_reg;

    logic [24:0]    head;
    logic           fifo_empty;
    logic           accept;
    logic           vs_fall;
    logic           slot;
    logic           pop_en;
    logic           sof_err;
    logic           arm_err;
    logic           flush;
    logic           wr_en;

    assign in_ready   = (level_reg < FULL_LEVEL);
    assign level      = level_reg;
    assign rgb_out    = rgb_reg;
    assign underflow  = underflow_reg;
    assign frame_err  = frame_err_reg;
    assign head       = mem[rd_ptr_reg];
    assign fifo_empty = (level_reg == '0);

    always_comb begin
        accept  = in_valid && in_ready;
        vs_fall = vs_reg && !vs;
        slot    = (state_reg == STREAM) && blank;
        pop_en  = slot && !fifo_empty;
        sof_err = pop_en && head[24] && (pix_cnt_reg != '0);
        arm_err = (state_reg == ARMED) && vs_fall && !fifo_empty && !head[24];
        flush   = sof_err || arm_err;
        // While hunting for a frame start, only the SOF word itself is kept.
        wr_en   = accept && !flush && ((state_reg != IDLE) || in_sof);
    end

    always_ff @(posedge pixel_clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= {in_sof, in_data};
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (pixel_rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_en) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({wr_en, pop_en})
                2'b10:   level_reg <= level_reg + 1'b1;
                2'b01:   level_reg <= level_reg - 1'b1;
                default: level_reg <= level_reg;
            endcase
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (pixel_rst) begin
            state_reg     <= IDLE;
            pix_cnt_reg   <= '0;
            vs_reg        <= 1'b1;
            rgb_reg       <= '0;
            underflow_reg <= 1'b0;
            frame_err_reg <= 1'b0;
        end else begin
            vs_reg        <= vs;
            rgb_reg       <= '0;
            underflow_reg <= 1'b0;
            frame_err_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (wr_en) begin
                        state_reg <= ARMED;
                    end
                end
                ARMED: begin
                    // An empty FIFO at sync just waits for the next sync edge.
                    if (vs_fall && !fifo_empty) begin
                        if (head[24]) begin
                            state_reg   <= STREAM;
                            pix_cnt_reg <= '0;
                        end else begin
                            frame_err_reg <= 1'b1;
                            state_reg     <= IDLE;
                        end
                    end
                end
                STREAM: begin
                    if (slot) begin
                        if (sof_err) begin
                            frame_err_reg <= 1'b1;
                            pix_cnt_reg   <= '0;
                            state_reg     <= IDLE;
                        end else begin
                            if (pop_en) begin
                                rgb_reg <= head[23:0];
                            end else begin
                                underflow_reg <= 1'b1;
                            end
                            if (pix_cnt_reg == LAST_SLOT) begin
                                pix_cnt_reg <= '0;
                                state_reg   <= ARMED;
                            end else begin
                                pix_cnt_reg <= pix_cnt_reg + 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_stream_buffer.sv
// Directed frame scenarios followed by random traffic, checked every cycle
// against a queue-based model of the buffer's frame rules.
module tb_pixel_stream_buffer;

    localparam int HDISP = 4;
    localparam int VDISP = 2;
    localparam int DEPTH = 4;
    localparam int TOTAL = HDISP * VDISP;

    logic        pixel_clk = 1'b0;
    logic        pixel_rst;
    logic [23:0] in_data;
    logic        in_sof;
    logic        in_valid;
    logic        in_ready;
    logic        vs;
    logic        blank;
    logic [23:0] rgb_out;
    logic        underflow;
    logic        frame_err;
    logic [2:0]  level;

    pixel_stream_buffer #(
        .HDISP(HDISP),
        .VDISP(VDISP),
        .DEPTH(DEPTH)
    ) dut (
        .pixel_clk(pixel_clk),
        .pixel_rst(pixel_rst),
        .in_data(in_data),
        .in_sof(in_sof),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .vs(vs),
        .blank(blank),
        .rgb_out(rgb_out),
        .underflow(underflow),
        .frame_err(frame_err),
        .level(level)
    );

    always #5 pixel_clk = ~pixel_clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit verbose  = 1'b1;

    // Reference model: a queue of {sof,data} words plus the frame phase.
    typedef enum int {M_IDLE, M_ARMED, M_STREAM} mphase_t;
    logic [24:0] q[$];
    mphase_t     m_phase;
    int          m_cnt;
    bit          m_vs_prev;
    logic [23:0] m_rgb;
    bit          m_uf;
    bit          m_fe;
    bit          m_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_step();
        bit          acc;
        bit          do_flush;
        bit          good;
        mphase_t     ph0;
        logic [24:0] w;
        m_acc = 1'b0;
        if (pixel_rst) begin
            q.delete();
            m_phase   = M_IDLE;
            m_cnt     = 0;
            m_rgb     = '0;
            m_uf      = 1'b0;
            m_fe      = 1'b0;
            m_vs_prev = 1'b1;
            return;
        end
        acc      = in_valid && (q.size() < DEPTH);
        m_acc    = acc;
        do_flush = 1'b0;
        m_rgb    = '0;
        m_uf     = 1'b0;
        m_fe     = 1'b0;
        ph0      = m_phase;
        if (ph0 == M_ARMED && m_vs_prev && !vs && q.size() > 0) begin
            if (q[0][24]) begin
                m_phase = M_STREAM;
                m_cnt   = 0;
            end else begin
                m_fe     = 1'b1;
                do_flush = 1'b1;
                m_phase  = M_IDLE;
            end
        end
        if (ph0 == M_STREAM && blank) begin
            good = 1'b1;
            if (q.size() > 0) begin
                w = q.pop_front();
                if (w[24] && m_cnt != 0) begin
                    m_fe     = 1'b1;
                    do_flush = 1'b1;
                    m_phase  = M_IDLE;
                    m_cnt    = 0;
                    good     = 1'b0;
                end else begin
                    m_rgb = w[23:0];
                end
            end else begin
                m_uf = 1'b1;
            end
            if (good) begin
                m_cnt++;
                if (m_cnt == TOTAL) begin
                    m_cnt   = 0;
                    m_phase = M_ARMED;
                end
            end
        end
        if (do_flush) begin
            q.delete();
        end else if (acc && (ph0 != M_IDLE || in_sof)) begin
            q.push_back({in_sof, in_data});
            if (ph0 == M_IDLE) m_phase = M_ARMED;
        end
        m_vs_prev = vs;
    endtask

    task automatic tick();
        model_step();
        @(posedge pixel_clk);
        #1;
        cyc++;
        chk("rgb_out", 32'(rgb_out), 32'(m_rgb));
        chk("underflow", 32'(underflow), 32'(m_uf));
        chk("frame_err", 32'(frame_err), 32'(m_fe));
        chk("level", 32'(level), 32'(q.size()));
        chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
        if (verbose)
            $display("cyc %0d rst=%0b v=%0b sof=%0b d=%h vs=%0b blank=%0b | rgb=%h uf=%0b fe=%0b level=%0d rdy=%0b",
                     cyc, pixel_rst, in_valid, in_sof, in_data, vs, blank,
                     rgb_out, underflow, frame_err, level, in_ready);
    endtask

    task automatic drive(input bit v, input bit s, input logic [23:0] d);
        in_valid = v;
        in_sof   = s;
        in_data  = d;
    endtask

    function automatic logic [23:0] pa(input int i);
        return 24'hA00000 + 24'(i);
    endfunction

    function automatic logic [23:0] pb(input int i);
        return 24'hB00000 + 24'(i);
    endfunction

    initial begin
        logic [24:0] cw [5];
        int idx;
        int j;

        pixel_rst = 1'b1;
        vs        = 1'b1;
        blank     = 1'b0;
        drive(0, 0, '0);
        tick();
        tick();
        chk("reset_rgb", 32'(rgb_out), 32'd0);
        chk("reset_level", 32'(level), 32'd0);
        pixel_rst = 1'b0;
        tick();
        chk("ready_after_reset", 32'(in_ready), 32'd1);

        // Non-SOF words before a frame start are dropped.
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 24'h0F0000 + 24'(i));
            tick();
        end
        chk("drop_non_sof", 32'(level), 32'd0);
        drive(1, 1, pa(0));
        tick();
        chk("sof_kept_level", 32'(level), 32'd1);

        // Full frame streamed while the source keeps topping up.
        for (int i = 1; i < 4; i++) begin
            drive(1, 0, pa(i));
            tick();
        end
        drive(0, 0, '0);
        chk("full_level", 32'(level), 32'd4);
        chk("full_not_ready", 32'(in_ready), 32'd0);
        vs = 1'b0;
        tick();
        vs = 1'b1;
        idx = 4;
        for (int s = 0; s < TOTAL; s++) begin
            blank = 1'b1;
            if (idx < TOTAL) drive(1, 0, pa(idx));
            else drive(0, 0, '0);
            tick();
            if (m_acc) idx++;
            chk("frame_a_pixel", 32'(rgb_out), 32'(pa(s)));
        end
        blank = 1'b0;
        drive(0, 0, '0);
        tick();

        // Short frame: three words then an empty slot.
        for (int i = 0; i < 3; i++) begin
            drive(1, i == 0, pb(i));
            tick();
        end
        drive(0, 0, '0);
        vs = 1'b0;
        tick();
        vs = 1'b1;
        blank = 1'b1;
        for (int s = 0; s < 4; s++) begin
            tick();
            chk("frame_b_pixel", 32'(rgb_out), (s < 3) ? 32'(pb(s)) : 32'd0);
            chk("frame_b_underflow", 32'(underflow), (s == 3) ? 32'd1 : 32'd0);
        end
        tick();
        blank = 1'b0;

        // Reset mid-frame discards everything; SOF needed again.
        pixel_rst = 1'b1;
        tick();
        pixel_rst = 1'b0;
        chk("midrst_rgb", 32'(rgb_out), 32'd0);
        chk("midrst_level", 32'(level), 32'd0);
        chk("midrst_uf", 32'(underflow), 32'd0);
        drive(1, 0, 24'h123456);
        tick();
        tick();
        chk("post_rst_needs_sof", 32'(level), 32'd0);

        // Back-pressure, then an early SOF at pixel 2 aborts the frame.
        cw[0] = {1'b1, 24'hC00000};
        cw[1] = {1'b0, 24'hC00001};
        cw[2] = {1'b1, 24'hC00002};
        cw[3] = {1'b0, 24'hC00003};
        cw[4] = {1'b0, 24'hC00004};
        j = 0;
        for (int k = 0; k < 6; k++) begin
            drive(1, cw[j][24], cw[j][23:0]);
            tick();
            if (m_acc && j < 4) j++;
        end
        chk("bp_level", 32'(level), 32'd4);
        chk("bp_not_ready", 32'(in_ready), 32'd0);
        vs = 1'b0;
        tick();
        vs = 1'b1;
        blank = 1'b1;
        tick();
        chk("c_pixel0", 32'(rgb_out), 32'hC00000);
        chk("c_ready_after_pop", 32'(in_ready), 32'd1);
        tick();
        chk("c_pixel1", 32'(rgb_out), 32'hC00001);
        chk("c_fifth_accepted", 32'(level), 32'd3);
        drive(0, 0, '0);
        tick();
        chk("early_sof_err", 32'(frame_err), 32'd1);
        chk("early_sof_flush", 32'(level), 32'd0);
        chk("early_sof_rgb", 32'(rgb_out), 32'd0);
        tick();
        chk("err_one_cycle", 32'(frame_err), 32'd0);
        blank = 1'b0;

        // Random traffic against the model.
        verbose = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            pixel_rst = ($urandom_range(0, 599) == 0);
            in_valid  = ($urandom_range(0, 9) < 7);
            in_sof    = ($urandom_range(0, 9) == 0);
            in_data   = 24'($urandom);
            blank     = ($urandom_range(0, 9) < 8);
            vs        = ($urandom_range(0, 11) != 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pixel_stream_buffer.md
PIXEL_STREAM_BUFFER -- requirements
Module: pixel_stream_buffer

Interface
REQ-001 Parameters SHALL be: HDISP 800, active pixels per line; VDISP 480, active lines per frame; DEPTH 16, FIFO entries (power of 2, at least 4).
REQ-002 pixel_clk  in  1  single clock; all logic on its rising edge.
REQ-003 pixel_rst  in  1  reset, synchronous, active-high.
REQ-004 in_data  in  24  upstream pixel, {R,G,B}.
REQ-005 in_sof  in  1  marks in_data as first pixel of a frame.
REQ-006 in_valid  in  1  upstream word present.
REQ-007 in_ready  out  1  buffer accepts word; transfer occurs when in_valid && in_ready.
REQ-008 vs  in  1  vertical sync from display timing, active-low pulse.
REQ-009 blank  in  1  display timing active-area flag; 1 = visible pixel slot.
REQ-010 rgb_out  out  24  pixel to display, registered.
REQ-011 underflow  out  1  one-cycle pulse: visible slot with FIFO empty.
REQ-012 frame_err  out  1  one-cycle pulse: SOF misalignment detected.
REQ-013 level  out  $clog2(DEPTH+1)  current FIFO occupancy.

Function
REQ-014 FIFO SHALL store 25-bit entries {sof, data}, DEPTH deep, with no write-to-read bypass; level SHALL equal pushes minus pops since the last flush.
REQ-015 in_ready SHALL be 1 when level < DEPTH, else 0, derived from registered state only.
REQ-016 Pop SHALL take priority over nothing; push and pop in the same cycle SHALL leave level unchanged.
REQ-017 FSM states SHALL be IDLE, ARMED and STREAM.
REQ-018 IDLE: in_ready per REQ-015; accepted words with in_sof=0 are discarded (not written); an accepted word with in_sof=1 is written and the FSM moves to ARMED.
REQ-019 ARMED: accepted words are written normally; no pops; on a vs falling edge (vs registered 1, current 0) with FIFO non-empty and head sof=1 -> STREAM, pixel count=0.
REQ-020 ARMED, vs falling edge with FIFO empty: remain ARMED; no error.
REQ-021 ARMED, vs falling edge with head sof=0: frame_err pulse, FIFO flushed, go to IDLE.
REQ-022 STREAM: each cycle with blank=1 is one pixel slot; pixel count increments by 1 per slot, width $clog2(HDISP*VDISP).
REQ-023 Slot with FIFO non-empty: pop head; rgb_out <= head data on the same edge, visible the next cycle (latency 1).
REQ-024 Slot with FIFO empty: rgb_out <= 0; underflow pulses on the next cycle; count still increments.
REQ-025 A popped word with sof=1 at count != 0 SHALL cause a frame_err pulse, rgb_out <= 0, FIFO flush and a move to IDLE.
REQ-026 The slot at count = HDISP*VDISP-1 SHALL complete the frame: count <= 0, FSM -> ARMED.
REQ-027 Cycles with blank=0 SHALL drive rgb_out <= 0 and pop nothing.
REQ-028 A flush SHALL drop any word pushed in the same cycle, and level SHALL read 0 on the next cycle.
REQ-029 Outside STREAM, rgb_out SHALL be 0 and underflow SHALL be 0.

Reset
REQ-030 On pixel_clk edge with pixel_rst=1: FSM=IDLE, FIFO empty, level=0, count=0, rgb_out=0, underflow=0, frame_err=0, registered vs=1.
REQ-031 in_ready SHALL be 1 on the cycle after reset deasserts.
REQ-032 Reset asserted mid-frame SHALL discard all buffered data; the first post-reset frame SHALL require a fresh SOF.

Verification (HDISP=4, VDISP=2, DEPTH=4)
REQ-033 Push 3 non-SOF words then SOF word A0 -> first 3 dropped, level=1, FSM=ARMED.
REQ-034 Push frame A0..A7 (A0 sof), vs falls, blank high for 8 slots -> rgb_out=A0..A7 one cycle after each slot, FSM=ARMED after slot 8.
REQ-035 Push only A0..A2, 4 visible slots -> rgb_out A0,A1,A2,0; one underflow pulse; count=4.
REQ-036 Push 5 words without popping -> in_ready=0 after 4th; level=4; 5th accepted only after first pop.
REQ-037 In STREAM at count=2, head word has sof=1 -> frame_err pulse, level=0 next cycle, FSM=IDLE.
REQ-038 Assert pixel_rst for 1 cycle at count=5 -> all outputs 0, level=0; next frame requires SOF.
